// File: rtl/rtc_read_seq_pkg.sv
// Shared definitions for the RTC read sequencer: register indices, FSM encoding
// and parameter defaults.
package rtc_read_seq_pkg;

    localparam int NUM_REGS_DEF = 9;
    localparam int TIMEOUT_DEF  = 255;

    localparam int IDX_W = 4;
    localparam int CNT_W = 8;

    localparam logic [IDX_W-1:0] REG_SEG   = 4'd0;
    localparam logic [IDX_W-1:0] REG_MIN   = 4'd1;
    localparam logic [IDX_W-1:0] REG_HORA  = 4'd2;
    localparam logic [IDX_W-1:0] REG_DIA   = 4'd3;
    localparam logic [IDX_W-1:0] REG_MES   = 4'd4;
    localparam logic [IDX_W-1:0] REG_ANO   = 4'd5;
    localparam logic [IDX_W-1:0] REG_TSEG  = 4'd6;
    localparam logic [IDX_W-1:0] REG_TMIN  = 4'd7;
    localparam logic [IDX_W-1:0] REG_THORA = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_NEXT  = 2'd3
    } seq_state_e;

    function automatic logic [IDX_W-1:0] last_index(input int num_regs);
        return IDX_W'(num_regs - 1);
    endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Loadable 8-bit down-counter guarding one bus transaction; saturates at zero
// and flags it.
module bus_timeout_cnt
    import rtc_read_seq_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rtc_read_seq.sv
// RTC register read sequencer: one bus read per index 0..NUM_REGS-1, each with a
// timeout, deferred while the write path owns the bus.
// state | meaning
// IDLE  | waiting for a refresh request (tick or pending)
// ISSUE | launching the bus read for the current index
// WAIT  | waiting for bus_done or timeout
// NEXT  | advancing the index or finishing the sequence
module rtc_read_seq
    import rtc_read_seq_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             tick_refresh_i,
    input  logic             wr_active_i,
    input  logic             bus_done_i,
    output logic [IDX_W-1:0] sel_reg_L_o,
    output logic             rd_req_o,
    output logic             cap_strobe_o,
    output logic             seq_busy_o,
    output logic             seq_done_o,
    output logic             timeout_err_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = last_index(NUM_REGS);
    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT);

    seq_state_e       state_q;
    logic [IDX_W-1:0] idx_q;
    logic             pending_q;
    logic             busy_q;
    logic             done_q;
    logic             rd_req_q;
    logic             terr_q;

    logic to_load;
    logic to_en;
    logic to_zero;

    assign to_load = (state_q == ST_ISSUE);
    assign to_en   = (state_q == ST_WAIT) && !bus_done_i;

    bus_timeout_cnt u_to_cnt (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .load_i     (to_load),
        .en_i       (to_en),
        .load_val_i (TO_LOAD),
        .zero_o     (to_zero)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= REG_SEG;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_req_q  <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            rd_req_q <= 1'b0;
            // Ticks arriving outside IDLE collapse into a single deferred request.
            if (tick_refresh_i && (state_q != ST_IDLE)) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (tick_refresh_i || pending_q) begin
                        if (wr_active_i) begin
                            pending_q <= 1'b1;
                        end else begin
                            state_q   <= ST_ISSUE;
                            idx_q     <= REG_SEG;
                            pending_q <= 1'b0;
                            terr_q    <= 1'b0;
                            busy_q    <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    rd_req_q <= 1'b1;
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion on the last counted cycle wins over the timeout.
                    if (bus_done_i) begin
                        state_q <= ST_NEXT;
                    end else if (to_zero) begin
                        terr_q  <= 1'b1;
                        state_q <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (!wr_active_i) begin
                        if (idx_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= ST_ISSUE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sel_reg_L_o   = idx_q;
    assign rd_req_o      = rd_req_q;
    assign cap_strobe_o  = (state_q == ST_WAIT) && bus_done_i && !reset_i;
    assign seq_busy_o    = busy_q;
    assign seq_done_o    = done_q;
    assign timeout_err_o = terr_q;

endmodule

// File: tb/tb_rtc_read_seq.sv
// Scoreboard bench for rtc_read_seq: directed sequences with a bus responder;
// a negedge monitor pops expected capture indices and error flags.
module tb_rtc_read_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       tick;
    logic       wr_active;
    logic       done_resp = 1'b0;
    logic       done_stray;
    logic       bus_done;
    logic [3:0] sel;
    logic       rd_req;
    logic       cap;
    logic       busy;
    logic       done;
    logic       terr;

    assign bus_done = done_resp | done_stray;

    rtc_read_seq dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .tick_refresh_i (tick),
        .wr_active_i    (wr_active),
        .bus_done_i     (bus_done),
        .sel_reg_L_o    (sel),
        .rd_req_o       (rd_req),
        .cap_strobe_o   (cap),
        .seq_busy_o     (busy),
        .seq_done_o     (done),
        .timeout_err_o  (terr)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus responder: bus_done arrives delay[idx] cycles after rd_req (0 = never).
    int delay [16];
    int resp_cnt = 0;
    always begin
        @(posedge clk);
        #1;
        done_resp = 1'b0;
        if (reset) begin
            resp_cnt = 0;
        end else begin
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) done_resp = 1'b1;
            end
            if (rd_req === 1'b1 && delay[sel] > 0) resp_cnt = delay[sel];
        end
    end

    // Scoreboard queues and monitor.
    int   exp_cap [$];
    logic exp_terr [$];
    int   rd_cyc [$];
    int   rd_sel [$];
    int   done_cyc [$];
    int   done_cnt = 0;
    int   mon_e;
    logic mon_t;

    always @(negedge clk) begin
        if (rd_req === 1'b1) begin
            rd_cyc.push_back(cyc);
            rd_sel.push_back(int'(sel));
        end
        if (cap === 1'b1) begin
            checks++;
            if (exp_cap.size() == 0) begin
                failures++;
                $display("FAIL cap_unexpected sel=%0d required=no strobe", sel);
            end else begin
                mon_e = exp_cap.pop_front();
                if (sel !== 4'(mon_e)) begin
                    failures++;
                    $display("FAIL cap_sel actual=%0d required=%0d", sel, mon_e);
                end
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            checks++;
            if (exp_terr.size() == 0) begin
                failures++;
                $display("FAIL seq_done_unexpected required=no pulse");
            end else begin
                mon_t = exp_terr.pop_front();
                if (terr !== mon_t) begin
                    failures++;
                    $display("FAIL done_terr actual=%0b required=%0b", terr, mon_t);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    task automatic sample_zero(input string name);
        @(negedge clk);
        check(name, {23'd0, sel, rd_req, cap, busy, done, terr}, 32'd0);
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            step(1);
            k++;
        end
        check(name, done_cnt, target);
    endtask

    task automatic wait_rd(input int n, input int budget, input string name);
        int k = 0;
        while (rd_cyc.size() < n && k < budget) begin
            step(1);
            k++;
        end
        check(name, rd_cyc.size(), n);
    endtask

    task automatic push_seq(input int skip, input logic t_err);
        for (int i = 0; i < 9; i++) if (i != skip) exp_cap.push_back(i);
        exp_terr.push_back(t_err);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=completion");
        $fatal(1, "watchdog");
    end

    int t0;
    int base;
    int target;
    int k;

    initial begin
        reset = 1'b1; tick = 1'b0; wr_active = 1'b0; done_stray = 1'b0;
        for (int i = 0; i < 16; i++) delay[i] = 3;
        step(2);
        sample_zero("reset_outputs");
        step(1);
        reset = 1'b0;
        step(2);
        sample_zero("idle_after_reset");
        step(1);

        // Basic sequence, latency and ordering.
        rd_cyc.delete(); rd_sel.delete();
        push_seq(-1, 1'b0);
        base = done_cnt;
        t0 = cyc;
        pulse_tick();
        check("busy_after_start", busy, 1);
        wait_done(base + 1, 200, "seqA_done");
        check("seqA_rd_count", rd_cyc.size(), 9);
        if (rd_cyc.size() > 0) check("seqA_latency", rd_cyc[0] - t0, 2);
        for (int i = 0; i < rd_cyc.size() && i < 9; i++) check("seqA_rd_sel", rd_sel[i], i);
        for (int i = 1; i < rd_cyc.size() && i < 9; i++) check("seqA_rd_gap", rd_cyc[i] - rd_cyc[i-1], 6);
        check("seqA_busy_cleared", busy, 0);
        check("seqA_sel_holds_last", sel, 8);
        step(20);
        check("seqA_single_done", done_cnt, base + 1);
        check("seqA_capq_empty", exp_cap.size(), 0);

        // Write path holds off the start.
        rd_cyc.delete(); rd_sel.delete();
        push_seq(-1, 1'b0);
        base = done_cnt;
        wr_active = 1'b1;
        pulse_tick();
        step(9);
        check("no_rd_while_wr", rd_cyc.size(), 0);
        check("no_busy_while_wr", busy, 0);
        wr_active = 1'b0;
        t0 = cyc;
        wait_done(base + 1, 200, "seqB_done");
        check("seqB_rd_count", rd_cyc.size(), 9);
        if (rd_cyc.size() > 0) begin
            check("seqB_release_latency", rd_cyc[0] - t0, 2);
            check("seqB_first_sel", rd_sel[0], 0);
        end

        // No response for index 4: full timeout.
        rd_cyc.delete(); rd_sel.delete();
        delay[4] = 0;
        push_seq(4, 1'b1);
        base = done_cnt;
        pulse_tick();
        wait_done(base + 1, 700, "seqC_done");
        check("seqC_rd_count", rd_cyc.size(), 9);
        if (rd_cyc.size() > 5) check("seqC_timeout_gap", rd_cyc[5] - rd_cyc[4], 258);
        step(5);
        check("seqC_terr_sticky", terr, 1);
        delay[4] = 3;

        // Stray bus_done in IDLE, then done coincident with counter zero.
        done_stray = 1'b1;
        @(negedge clk);
        check("cap_outside_wait", cap, 0);
        step(1);
        done_stray = 1'b0;
        rd_cyc.delete(); rd_sel.delete();
        delay[2] = 255;
        push_seq(-1, 1'b0);
        base = done_cnt;
        pulse_tick();
        check("terr_cleared_on_start", terr, 0);
        wait_done(base + 1, 700, "seqD_done");
        if (rd_cyc.size() > 3) check("seqD_edge_gap", rd_cyc[3] - rd_cyc[2], 258);
        delay[2] = 3;

        // Several ticks while busy collapse to one extra sequence.
        rd_cyc.delete(); rd_sel.delete();
        push_seq(-1, 1'b0);
        push_seq(-1, 1'b0);
        base = done_cnt;
        pulse_tick();
        for (int i = 0; i < 3; i++) begin
            step(5);
            pulse_tick();
        end
        wait_done(base + 2, 400, "seqE_done");
        check("seqE_rd_count", rd_cyc.size(), 18);
        if (rd_cyc.size() > 9 && done_cyc.size() > base)
            check("seqE_restart_gap", rd_cyc[9] - done_cyc[base], 2);
        step(30);
        check("seqE_no_third", done_cnt, base + 2);

        // Tick on the finishing NEXT cycle.
        rd_cyc.delete(); rd_sel.delete();
        push_seq(-1, 1'b0);
        push_seq(-1, 1'b0);
        base = done_cnt;
        pulse_tick();
        wait_rd(9, 200, "seqF_rd9");
        target = (rd_cyc.size() > 8) ? rd_cyc[8] + 4 : cyc;
        k = 0;
        while (cyc < target && k < 20) begin
            step(1);
            k++;
        end
        pulse_tick();
        wait_done(base + 2, 400, "seqF_done");
        if (rd_cyc.size() > 9 && done_cyc.size() > base) begin
            check("seqF_done_cycle", done_cyc[base], target + 1);
            check("seqF_restart_gap", rd_cyc[9] - done_cyc[base], 2);
        end
        check("seqF_rd_count", rd_cyc.size(), 18);

        // Reset mid-sequence at index 5.
        rd_cyc.delete(); rd_sel.delete();
        for (int i = 0; i < 5; i++) exp_cap.push_back(i);
        base = done_cnt;
        pulse_tick();
        wait_rd(6, 100, "seqG_rd6");
        check("seqG_sel_at_reset", sel, 5);
        reset = 1'b1;
        step(1);
        sample_zero("abort_outputs");
        step(1);
        reset = 1'b0;
        step(10);
        check("abort_no_done", done_cnt, base);
        check("abort_no_more_rd", rd_cyc.size(), 6);
        check("abort_capq_empty", exp_cap.size(), 0);
        rd_cyc.delete(); rd_sel.delete();
        push_seq(-1, 1'b0);
        pulse_tick();
        wait_done(base + 1, 200, "seqG_restart_done");
        if (rd_sel.size() > 0) check("seqG_restart_sel", rd_sel[0], 0);
        check("seqG_rd_count", rd_cyc.size(), 9);

        step(5);
        check("final_capq_empty", exp_cap.size(), 0);
        check("final_terrq_empty", exp_terr.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
